// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the minimum legal divisor, default counter width and high-phase helper.
package clk_div_pkg;

    localparam int MIN_DIV       = 2;
    localparam int CNT_WIDTH_DEF = 8;

    // High-phase length for divisor n; odd divisors give the extra cycle
    // to the high phase.
    function automatic logic [31:0] half_high(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Divisor shadow register: accepts runtime loads and commits them at a wrap.
// Ports: clk, rst (sync, active-high), div_load/div_val (load request),
//        wrap (period boundary strobe), div_active (divisor in effect),
//        cfg_err (one-cycle pulse on a rejected load).
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_load,
    input  logic [CNT_WIDTH-1:0] div_val,
    input  logic                 wrap,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 cfg_err
);

    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [CNT_WIDTH-1:0] div_active_q, div_active_d;
    logic                 cfg_err_q, cfg_err_d;

    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        div_active_d    = div_active_q;
        cfg_err_d       = 1'b0;

        // Commit the value pending before this edge; a load arriving on the
        // same edge is kept for the following wrap.
        if (wrap && pending_valid_q) begin
            div_active_d    = pending_q;
            pending_valid_d = 1'b0;
        end

        if (div_load) begin
            if (div_val >= CNT_WIDTH'(MIN_DIV)) begin
                pending_d       = div_val;
                pending_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            div_active_q    <= CNT_WIDTH'(DEFAULT_DIV);
            cfg_err_q       <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            div_active_q    <= div_active_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    assign div_active = div_active_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable integer clock divider with a clk-domain tick strobe.
// Ports: clk, rst (sync, active-high), en (count enable), div_val/div_load
//        (divisor request), out_clk (divided clock), out_tick (rise strobe),
//        div_active (divisor in effect), cfg_err (rejected load pulse).
// Optional: define PERIOD_COUNT_EN to add period_cnt[15:0], a count of ticks.
module programmable_clock_divider
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_val,
    input  logic                 div_load,
    output logic                 out_clk,
    output logic                 out_tick,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 cfg_err
`ifdef PERIOD_COUNT_EN
    ,
    output logic [15:0]          period_cnt
`endif
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_clk_q, out_clk_d;
    logic                 out_tick_q, out_tick_d;
    logic [CNT_WIDTH:0]   half;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 wrap;

    clk_div_cfg_shadow #(
        .CNT_WIDTH   (CNT_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .div_load   (div_load),
        .div_val    (div_val),
        .wrap       (wrap),
        .div_active (div_active),
        .cfg_err    (cfg_err)
    );

    always_comb begin
        half    = (CNT_WIDTH+1)'(half_high(32'(div_active)));
        // One extra bit so cnt+1 can be compared against half without wrap.
        cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
        wrap    = en && (cnt_q == div_active - CNT_WIDTH'(1));

        cnt_d      = cnt_q;
        out_clk_d  = out_clk_q;
        out_tick_d = 1'b0;

        if (wrap) begin
            cnt_d      = '0;
            out_clk_d  = 1'b1;
            out_tick_d = 1'b1;
        end else if (en) begin
            cnt_d     = cnt_inc[CNT_WIDTH-1:0];
            out_clk_d = cnt_inc < half;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= CNT_WIDTH'(DEFAULT_DIV - 1);
            out_clk_q  <= 1'b0;
            out_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            out_clk_q  <= out_clk_d;
            out_tick_q <= out_tick_d;
        end
    end

    assign out_clk  = out_clk_q;
    assign out_tick = out_tick_q;

`ifdef PERIOD_COUNT_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    // Advances on the same edge that raises out_tick; wraps naturally.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (wrap) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider.
// Scoreboard of expected per-cycle outputs plus directed pattern checks.
module tb_programmable_clock_divider;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         div_load;
    logic [W-1:0] div_val;
    logic         out_clk;
    logic         out_tick;
    logic [W-1:0] div_active;
    logic         cfg_err;
`ifdef PERIOD_COUNT_EN
    logic [15:0]  period_cnt;
`endif

    always #5 clk = ~clk;

    programmable_clock_divider #(
        .CNT_WIDTH   (W),
        .DEFAULT_DIV (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .out_clk    (out_clk),
        .out_tick   (out_tick),
        .div_active (div_active),
        .cfg_err    (cfg_err)
`ifdef PERIOD_COUNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    typedef struct {
        logic        oc;
        logic        tk;
        logic [15:0] act;
        logic        err;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference state
    int   m_cnt;
    int   m_n;
    int   m_pend;
    bit   m_pv;
    logic m_oc;
    logic m_tk;
    logic m_err;
    int   m_pc;

    logic [31:0] pat;
    logic [31:0] tpat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic ld,
                        input logic [W-1:0] v);
        exp_t x;
        rst      = r;
        en       = e;
        div_load = ld;
        div_val  = v;

        if (r) begin
            m_cnt = D - 1;
            m_n   = D;
            m_pv  = 0;
            m_oc  = 1'b0;
            m_tk  = 1'b0;
            m_err = 1'b0;
            m_pc  = 0;
        end else begin
            m_err = ld && (int'(v) < 2);
            m_tk  = 1'b0;
            if (e) begin
                if (m_cnt == m_n - 1) begin
                    m_cnt = 0;
                    m_tk  = 1'b1;
                    m_pc  = (m_pc + 1) % 65536;
                    if (m_pv) begin
                        m_n  = m_pend;
                        m_pv = 0;
                    end
                end else begin
                    m_cnt++;
                end
                m_oc = (m_cnt < (m_n + 1) / 2);
            end
            if (ld && int'(v) >= 2) begin
                m_pend = int'(v);
                m_pv   = 1;
            end
        end

        x.oc  = m_oc;
        x.tk  = m_tk;
        x.act = 16'(m_n);
        x.err = m_err;
        x.pc  = 16'(m_pc);
        sb.push_back(x);

        @(posedge clk);
        #1;

        x = sb.pop_front();
        chk("out_clk", 32'(out_clk), 32'(x.oc));
        chk("out_tick", 32'(out_tick), 32'(x.tk));
        chk("div_active", 32'(div_active), 32'(x.act));
        chk("cfg_err", 32'(cfg_err), 32'(x.err));
`ifdef PERIOD_COUNT_EN
        chk("period_cnt", 32'(period_cnt), 32'(x.pc));
`endif
        pat  = {pat[30:0], out_clk};
        tpat = {tpat[30:0], out_tick};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    initial begin
        m_pend = 0;
        pat    = '0;
        tpat   = '0;

        // Reset
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("rst_out_clk", 32'(out_clk), 32'd0);
        chk("rst_div_active", 32'(div_active), 32'd2);

        // Divide by 2 from reset
        pat = '0; tpat = '0;
        run(10);
        chk("div2_pat", pat, 32'b1010101010);
        chk("div2_tick", tpat, 32'b1010101010);
        chk("div2_act", 32'(div_active), 32'd2);

        // Load 5 mid-period; N=2 period finishes first
        run(1);
        step(1'b0, 1'b1, 1'b1, 8'd5);
        chk("ld5_before_wrap", 32'(div_active), 32'd2);
        pat = '0;
        run(10);
        chk("div5_pat", pat, 32'b1110011100);
        chk("div5_act", 32'(div_active), 32'd5);

        // Load 6 then 3 back to back; newest wins
        run(1);
        step(1'b0, 1'b1, 1'b1, 8'd6);
        step(1'b0, 1'b1, 1'b1, 8'd3);
        run(2);
        pat = '0;
        run(9);
        chk("div3_pat", pat, 32'b110110110);
        chk("div3_act", 32'(div_active), 32'd3);

        // Rejected loads
        step(1'b0, 1'b1, 1'b1, 8'd1);
        chk("err_v1", 32'(cfg_err), 32'd1);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        chk("err_v0", 32'(cfg_err), 32'd1);
        run(1);
        chk("err_clear", 32'(cfg_err), 32'd0);
        pat = '0;
        run(6);
        chk("err_pat", pat, 32'b110110);
        chk("err_act", 32'(div_active), 32'd3);

        // N=4, freeze for 4 cycles just after a rising edge
        step(1'b0, 1'b1, 1'b1, 8'd4);
        run(3);
        chk("div4_act", 32'(div_active), 32'd4);
        pat = '0; tpat = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
        end
        run(4);
        chk("freeze_pat", pat, 32'b11111001);
        chk("freeze_tick", tpat, 32'b00000001);

        // N=7 then reset mid-period with a load pending
        step(1'b0, 1'b1, 1'b1, 8'd7);
        run(3);
        chk("div7_act", 32'(div_active), 32'd7);
        step(1'b0, 1'b1, 1'b1, 8'd9);
        run(1);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("mid_rst_oc", 32'(out_clk), 32'd0);
        chk("mid_rst_act", 32'(div_active), 32'd2);
`ifdef PERIOD_COUNT_EN
        chk("mid_rst_pc", 32'(period_cnt), 32'd0);
`endif
        pat = '0;
        run(6);
        chk("post_rst_pat", pat, 32'b101010);
        chk("post_rst_act", 32'(div_active), 32'd2);
`ifdef PERIOD_COUNT_EN
        chk("post_rst_pc", 32'(period_cnt), 32'd3);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
